// File: rtl/instr_fetch_pkg.sv
// Shared fetch/decode definitions: opcode field values, default stop code, fetch state encoding.
package instr_fetch_pkg;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_JUMP  = 2'b11;

  localparam logic [7:0] HALT_CODE_DEF = 8'hC3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  function automatic logic [7:0] sext6(input logic [5:0] off);
    return {{2{off[5]}}, off};
  endfunction

endpackage

// File: rtl/instr_fetch_next_pc.sv
// Combinational next-PC: sequential step or relative jump, wrapped to the memory depth.
module instr_fetch_next_pc
  import instr_fetch_pkg::*;
#(
  parameter int MEM_DEPTH = 32
) (
  input  logic [7:0] pc,
  input  logic [7:0] instruction,
  input  logic       jump,
  output logic [7:0] next_pc
);

  // MEM_DEPTH is a power of two <= 256, so 8-bit wrap then mask is exact modulo.
  localparam logic [7:0] MASK = 8'(MEM_DEPTH - 1);

  logic [7:0] step;

  assign step    = jump ? (8'd1 + sext6(instruction[5:0])) : 8'd1;
  assign next_pc = (pc + step) & MASK;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, IR handshake with decode, local jumps and halt detection.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int         MEM_DEPTH = 32,
  parameter logic [7:0] HALT_CODE = HALT_CODE_DEF
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       run,
  input  logic       dec_ready,
  input  logic [7:0] instruction,
  output logic [7:0] address,
  output logic [7:0] ir,
  output logic       ir_valid,
  output logic       halted,
  output logic [7:0] instr_count
);

  fetch_state_e state;
  logic [7:0]   pc, next_pc;
  logic         capture, is_halt, is_jump;

  assign capture = (state == ST_RUN) && run && (!ir_valid || dec_ready);
  assign is_halt = (instruction == HALT_CODE);
  assign is_jump = (instruction[7:6] == OP_JUMP) && !is_halt;
  assign address = pc;

  instr_fetch_next_pc #(.MEM_DEPTH(MEM_DEPTH)) u_next_pc (
    .pc          (pc),
    .instruction (instruction),
    .jump        (is_jump),
    .next_pc     (next_pc)
  );

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state       <= ST_IDLE;
      pc          <= '0;
      ir          <= '0;
      ir_valid    <= 1'b0;
      halted      <= 1'b0;
      instr_count <= '0;
    end else begin
      case (state)
        ST_IDLE: if (run) state <= ST_RUN;
        ST_RUN: begin
          if (!run) state <= ST_IDLE;
          else if (capture && is_halt) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_IDLE;
      endcase

      if (capture) begin
        if (instr_count != 8'hFF) instr_count <= instr_count + 8'd1;
        if (is_halt) begin
          ir_valid <= 1'b0;
        end else if (is_jump) begin
          pc       <= next_pc;
          ir_valid <= 1'b0;
        end else begin
          // New word wins over a same-cycle consume, so ir_valid stays set.
          ir       <= instruction;
          ir_valid <= 1'b1;
          pc       <= next_pc;
        end
      end else if (ir_valid && dec_ready) begin
        ir_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural instruction memory.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       clear, run, dec_ready;
  logic [7:0] instruction, address, ir, instr_count;
  logic       ir_valid, halted;
  logic [7:0] mem [0:255];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign instruction = mem[address];

  instr_fetch #(.MEM_DEPTH(32), .HALT_CODE(8'hC3)) dut (
    .clk         (clk),
    .clear       (clear),
    .run         (run),
    .dec_ready   (dec_ready),
    .instruction (instruction),
    .address     (address),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .halted      (halted),
    .instr_count (instr_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  // Pulse clear between edges and leave inputs idle.
  task automatic do_clear();
    @(negedge clk);
    run = 1'b0; dec_ready = 1'b0;
    clear = 1'b1;
    #2 clear = 1'b0;
  endtask

  logic [7:0] prog [0:10];
  int k;

  initial begin
    prog = '{8'h49, 8'h61, 8'h45, 8'h07, 8'h79, 8'h2C, 8'hA2, 8'h0D, 8'h7B, 8'h1E, 8'hC3};
    fill(8'h00);
    run = 1'b0; dec_ready = 1'b0; clear = 1'b1;
    #2;
    chk("rst_addr", address, 0);
    chk("rst_ir", ir, 0);
    chk("rst_valid", ir_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_count", instr_count, 0);

    // Straight-line program ending in HALT_CODE at address 10.
    for (int i = 0; i < 11; i++) mem[i] = prog[i];
    @(negedge clk);
    clear = 1'b0; run = 1'b1; dec_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) chk("first_edge_cnt", instr_count, 0);
      if (halted) break;
      if (ir_valid) begin
        if (k < 10) chk($sformatf("seq_ir%0d", k), ir, prog[k]);
        k++;
      end
    end
    chk("seq_len", k, 10);
    chk("seq_halted", halted, 1);
    chk("seq_addr", address, 10);
    chk("seq_count", instr_count, 11);
    chk("seq_valid", ir_valid, 0);
    chk("seq_ir_last", ir, 8'h1E);
    run = 1'b0;
    repeat (2) @(negedge clk);
    chk("halt_sticky", halted, 1);
    run = 1'b1;
    @(negedge clk);
    chk("halt_count_frozen", instr_count, 11);
    #2 clear = 1'b1;
    #1;
    chk("aclr_halt_halted", halted, 0);
    chk("aclr_halt_addr", address, 0);
    chk("aclr_halt_count", instr_count, 0);
    #1 clear = 1'b0;

    // Stall: 49 held while decode is not ready.
    fill(8'h00);
    mem[0] = 8'h49; mem[1] = 8'h07;
    do_clear();
    run = 1'b1; dec_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("stall_cap_ir", ir, 8'h49);
    chk("stall_cap_addr", address, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("stall_ir%0d", c), ir, 8'h49);
      chk($sformatf("stall_v%0d", c), ir_valid, 1);
      chk($sformatf("stall_a%0d", c), address, 1);
    end
    dec_ready = 1'b1;
    @(negedge clk);
    chk("stall_next_ir", ir, 8'h07);
    chk("stall_next_v", ir_valid, 1);
    chk("stall_next_addr", address, 2);
    chk("stall_count", instr_count, 2);
    dec_ready = 1'b0;
    @(negedge clk);
    #2 clear = 1'b1;
    #1;
    chk("aclr_v_ir", ir, 0);
    chk("aclr_v_valid", ir_valid, 0);
    chk("aclr_v_addr", address, 0);
    chk("aclr_v_count", instr_count, 0);
    #1 clear = 1'b0;

    // Forward jump C2 at address 5 lands on 8.
    fill(8'h00);
    mem[4] = 8'h11; mem[5] = 8'hC2; mem[8] = 8'h0A;
    do_clear();
    run = 1'b1; dec_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (address == 8'd5) break;
    end
    chk("jmp_at5", address, 5);
    chk("jmp_pre_ir", ir, 8'h11);
    @(negedge clk);
    chk("jmp_addr8", address, 8);
    chk("jmp_valid0", ir_valid, 0);
    chk("jmp_ir_held", ir, 8'h11);
    @(negedge clk);
    chk("jmp_tgt_ir", ir, 8'h0A);
    chk("jmp_tgt_valid", ir_valid, 1);
    chk("jmp_tgt_addr", address, 9);

    // Backward jump wraps below zero; sequential step wraps past the top.
    fill(8'h00);
    mem[0] = 8'hFE; mem[31] = 8'h3C;
    do_clear();
    run = 1'b1; dec_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("wrap_addr31", address, 31);
    chk("wrap_v0", ir_valid, 0);
    @(negedge clk);
    chk("wrap_addr0", address, 0);
    chk("wrap_ir", ir, 8'h3C);
    run = 1'b0;
    repeat (2) @(negedge clk);
    chk("norun_addr", address, 0);
    chk("norun_ir", ir, 8'h3C);
    chk("norun_count", instr_count, 2);
    chk("norun_consumed", ir_valid, 0);

    // Tight self-loop saturates the counter.
    fill(8'h00);
    mem[0] = 8'hFF;
    do_clear();
    run = 1'b1; dec_ready = 1'b1;
    repeat (301) @(negedge clk);
    chk("sat_count", instr_count, 255);
    chk("sat_addr", address, 0);
    chk("sat_valid", ir_valid, 0);
    chk("sat_halted", halted, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 32, meaning instruction words addressable (power of two, 2..256).
REQ-002 SHALL have parameter HALT_CODE, default 8'hC3, meaning the stop instruction encoding.
REQ-003 SHALL have port clk  input  1  the single clock, rising-edge active.
REQ-004 SHALL have port clear  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port run  input  1  fetch enable.
REQ-006 SHALL have port dec_ready  input  1  decode stage accepts ir this cycle.
REQ-007 SHALL have port instruction  input  8  combinational instruction-memory read data for address.
REQ-008 SHALL have port address  output  8  instruction-memory address, equal to the PC zero-extended.
REQ-009 SHALL have port ir  output  8  registered instruction presented to decode.
REQ-010 SHALL have port ir_valid  output  1  ir holds an unconsumed instruction.
REQ-011 SHALL have port halted  output  1  HALT_CODE fetched, fetch frozen.
REQ-012 SHALL have port instr_count  output  8  instructions fetched since reset, saturating.

Function
REQ-013 SHALL implement states IDLE, RUN and HALT, with halted high exactly in HALT.
REQ-014 SHALL transition IDLE->RUN on run=1, RUN->IDLE on run=0 and RUN->HALT on capture of HALT_CODE; HALT SHALL be left only by clear.
REQ-015 SHALL define capture as state==RUN && run==1 && (!ir_valid || dec_ready), evaluated at each rising clk.
REQ-016 On capture of opcode [7:6] in {00,01,10}, SHALL load ir<=instruction, set ir_valid<=1 and set pc<=(pc+1) mod MEM_DEPTH.
REQ-017 On capture of opcode 11 other than HALT_CODE (jump), SHALL set pc<=(pc+1+sext(instruction[5:0])) mod MEM_DEPTH, SHALL NOT forward the jump to ir, and SHALL clear ir_valid.
REQ-018 On capture of HALT_CODE, SHALL hold pc, SHALL NOT forward HALT_CODE, SHALL clear ir_valid and SHALL enter HALT.
REQ-019 SHALL increment instr_count by 1 on every capture, including jump and HALT, and SHALL saturate it at 255.
REQ-020 Without capture, ir_valid && dec_ready SHALL clear ir_valid, while ir_valid && !dec_ready SHALL hold ir and ir_valid unchanged in every state.
REQ-021 SHALL give a simultaneous consume and capture the new word priority, so ir_valid remains 1 with the new ir.
REQ-022 address SHALL be combinationally equal to pc, with fetch latency one cycle from address to ir.
REQ-023 SHALL not change pc, ir or instr_count while run=0.

Reset
REQ-024 clear SHALL asynchronously force state=IDLE, pc=0, ir=8'h00, ir_valid=0, halted=0 and instr_count=0.
REQ-025 clear asserted mid-operation, including in HALT or with ir_valid && !dec_ready, SHALL discard the pending ir.
REQ-026 After clear deasserts, the first capture SHALL occur no earlier than the first rising edge with run=1.

Structure
REQ-027 A shared package SHALL hold the opcode constants (ADD=00, LOAD=01, STORE=10, JUMP=11), the default HALT_CODE and the state encoding, all shared with the decode stage.
REQ-028 Next-PC arithmetic (increment, sign-extended offset, modulo wrap) SHALL reside in one sub-module, instr_fetch_next_pc, which is purely combinational.

Verification
REQ-029 Load the 11-word program ending in 8'hC3 at address 10 and hold run=1, dec_ready=1 -> ir sequence is 49,61,45,07,79,2C,A2,0D,7B,1E, halted rises after the 11th edge, address=10 and instr_count=11.
REQ-030 Capture 8'h49 and then drop dec_ready for 5 cycles -> ir holds 49, ir_valid=1 and address=1 throughout; the next capture occurs on the first edge with dec_ready=1.
REQ-031 Place 8'hC2 at address 5 -> address steps 5 to 8, ir_valid=0 for one cycle, and the jump is not forwarded.
REQ-032 Place 8'hFE at address 0 -> address becomes 31; a non-jump word at address 31 -> address becomes 0.
REQ-033 Assert clear asynchronously mid-cycle with ir_valid=1 and then again in HALT -> all outputs reach their reset values immediately, without a clock edge.
REQ-034 Run a 300-instruction jump loop -> instr_count saturates at 255.
